// File: rtl/act_mem_pingpong_ctrl.sv
// Layer sequencer and host-access gate for the double-buffered activation memory.
// The engine reads half `cur` and writes half ~cur; the host may only touch the input half while a layer runs.
module act_mem_pingpong_ctrl #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-2:0] cfg_in_base,
  input  logic [ADDR_W-2:0] cfg_out_base,
  input  logic              cfg_swap,
  input  logic              cfg_last,
  input  logic              abort,
  output logic              eng_start,
  input  logic              eng_done,
  output logic [ADDR_W-1:0] input_memory_pointer,
  output logic [ADDR_W-1:0] output_memory_pointer,
  output logic              busy,
  output logic              seq_done,
  output logic [CNT_W-1:0]  layer_cnt,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  output logic              ext_gnt,
  output logic              rd_en_ext,
  output logic              wr_en_ext,
  output logic [1:0]        state_dbg
);

  // Descriptor handshake: a descriptor transfers on any cycle where cfg_valid && cfg_ready;
  // cfg_ready is high only in IDLE and does not depend on cfg_valid.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              cur;
  logic [ADDR_W-2:0] in_base_q, out_base_q;
  logic              swap_q, last_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              seq_done_q;
  logic              accept, layer_end;

  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    eng_start = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    layer_end = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          accept    = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        eng_start = 1'b1;
        busy      = 1'b1;
        state_nxt = abort ? IDLE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        // abort takes priority: the cancelled layer neither swaps nor counts
        if (abort) begin
          state_nxt = IDLE;
        end else if (eng_done) begin
          layer_end = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur        <= 1'b0;
      in_base_q  <= '0;
      out_base_q <= '0;
      swap_q     <= 1'b0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      seq_done_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      seq_done_q <= layer_end & last_q;
      if (accept) begin
        in_base_q  <= cfg_in_base;
        out_base_q <= cfg_out_base;
        swap_q     <= cfg_swap;
        last_q     <= cfg_last;
      end
      if (layer_end) begin
        if (swap_q) cur <= ~cur;
        cnt_q <= last_q ? '0 : cnt_q + CNT_W'(1);
      end
    end
  end

  // Pointers are pure concatenations of registers, so they only move on accept or swap.
  assign input_memory_pointer  = {cur, in_base_q};
  assign output_memory_pointer = {~cur, out_base_q};
  assign seq_done  = seq_done_q;
  assign layer_cnt = cnt_q;
  assign state_dbg = state;

  // While a layer is in flight the host may only read the input half.
  assign ext_gnt   = ext_req & ((state == IDLE) | (~ext_we & (ext_addr[ADDR_W-1] == cur)));
  assign rd_en_ext = ext_req & ~ext_we & ext_gnt;
  assign wr_en_ext = ext_req & ext_we & ext_gnt;

endmodule
